lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the statistics counters.
REQ-002 Parameter RAM_AW, default 12: RAM byte-address width; legal byte addresses are 0 .. 2**RAM_AW-1.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 clr  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  CPU request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 mem_rd, mem_wr  in  1 each  load / store request.
REQ-008 size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 unsigned_ld  in  1  1 = zero-extend the load result, 0 = sign-extend it.
REQ-010 addr  in  32  byte address.
REQ-011 wdata  in  32  store data, right-aligned.
REQ-012 ram_addr  out  RAM_AW  RAM byte address.
REQ-013 ram_din  out  32  RAM write data.
REQ-014 ram_mode  out  2  RAM access size, same encoding as size.
REQ-015 ram_we  out  1  RAM write enable.
REQ-016 ram_sel  out  1  RAM select.
REQ-017 ram_dout  in  32  RAM read data.
  - Combinational.
  - Already right-aligned and zero-filled above the access width.
REQ-018 rsp_valid  out  1  response present.
REQ-019 rsp_ready  in  1  CPU accepts the response.
REQ-020 rdata  out  32  load result; 0 for stores and errors.
REQ-021 addr_err  out  1  request rejected.
REQ-022 load_cnt, store_cnt, err_cnt  out  CNT_W each  statistics counters.

Function
REQ-023 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-024 req_ready SHALL be 1 only in IDLE.
REQ-025 Acceptance (IDLE and req_valid) SHALL register mem_rd, mem_wr, size, unsigned_ld, addr[RAM_AW-1:0] and wdata.
  - Accepting a request with mem_rd=0 and mem_wr=0 SHALL have no effect; the FSM stays in IDLE.
REQ-026 On acceptance, the request SHALL be an error if any of these holds:
  - mem_rd and mem_wr are both 1;
  - size is 11;
  - size is 01 and addr[0] is 1;
  - size is 10 and addr[1:0] is not 00;
  - addr[31:RAM_AW] is nonzero.
REQ-027 On acceptance, an error request SHALL go IDLE->RESP with addr_err=1 and no RAM access.
  - A legal request SHALL go IDLE->ACCESS.
REQ-028 ACCESS SHALL last exactly one cycle.
  - ram_sel=1 for that cycle.
  - ram_we = registered mem_wr and not clr.
  - ram_addr, ram_mode and ram_din come from the registered request.
  - Next state is RESP.
REQ-029 Outside ACCESS, ram_sel and ram_we SHALL be 0; ram_addr, ram_mode and ram_din hold their last values.
REQ-030 At the end of ACCESS, a load SHALL capture rdata from ram_dout:
  - byte: 8 bits, sign- or zero-extended per unsigned_ld;
  - half: 16 bits, sign- or zero-extended per unsigned_ld;
  - word: unchanged.
REQ-031 In RESP, rsp_valid SHALL be 1, and rdata and addr_err SHALL be held stable until rsp_ready=1.
  - Then the FSM goes RESP->IDLE, and rsp_valid, rdata and addr_err clear on that edge.
REQ-032 Timing from acceptance at edge T:
  - RAM access in cycle T+1;
  - store committed at edge T+2;
  - rsp_valid from T+2;
  - minimum request-to-request spacing of 3 cycles.
REQ-033 Each counter SHALL increment by 1 when RESP is left (rsp_valid and rsp_ready):
  - load_cnt for a successful load;
  - store_cnt for a successful store;
  - err_cnt for an addr_err response.
  - Counters saturate at 2**CNT_W-1 (no wrap-around).
REQ-034 A request with req_valid asserted outside IDLE SHALL be ignored; the CPU holds it until req_ready.

Reset
REQ-035 When clr=1 at a posedge, the block SHALL go to IDLE, with all outputs and counters 0 and registered request fields 0.
  - This has priority over every other transition.
REQ-036 clr=1 during ACCESS SHALL force ram_we=0 combinationally in that cycle; no response is produced.
REQ-037 clr=1 during RESP SHALL drop the pending response without counting it.

Verification
REQ-038 Store word then load word:
  - sw addr=0x10, wdata=0xDEADBEEF -> ram_we=1 for one cycle with ram_mode=10, ram_addr=0x010; response after 2 cycles, store_cnt=1.
  - lw 0x10 -> rdata=0xDEADBEEF, load_cnt=1.
REQ-039 Byte extension: sb addr=0x21, wdata=0x80.
  - lb 0x21 -> rdata=0xFFFFFF80.
  - lbu 0x21 -> rdata=0x00000080.
REQ-040 Halfword extension: sh addr=0x32, wdata=0x8001.
  - lh 0x32 -> rdata=0xFFFF8001.
  - lhu 0x32 -> rdata=0x00008001.
REQ-041 Errors, each -> addr_err=1, ram_sel never 1, err_cnt increments:
  - lw addr=0x13;
  - lh addr=0x01;
  - size=11;
  - addr=0x1000;
  - mem_rd=mem_wr=1.
REQ-042 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and addr_err stable and req_ready=0 throughout.
  - Release -> IDLE on the next cycle.
REQ-043 Reset and saturation:
  - clr=1 in the ACCESS cycle of sw 0x40 -> ram_we=0, no rsp_valid, later lw 0x40 returns 0.
  - With CNT_W=2, 5 successful loads -> load_cnt=3.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: validates CPU requests, drives one RAM
// access cycle, extends load data and holds the response for the CPU.
module lsu_ctrl #(
  parameter int CNT_W  = 16,
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic [1:0]        ram_mode,
  output logic              ram_we,
  output logic              ram_sel,
  input  logic [31:0]       ram_dout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rdata,
  output logic              addr_err,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e st_q, st_d;

  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]  st_cnt_q, st_cnt_d;
  logic [CNT_W-1:0]  er_cnt_q, er_cnt_d;

  logic        req_err;
  logic        hi_nz;
  logic [31:0] ld_ext;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign hi_nz = (addr >> RAM_AW) != 32'd0;

  assign req_err = (mem_rd && mem_wr)
                || (size == 2'b11)
                || (size == 2'b01 && addr[0])
                || (size == 2'b10 && addr[1:0] != 2'b00)
                || hi_nz;

  always_comb begin
    ld_ext = ram_dout;
    unique case (size_q)
      2'b00: ld_ext = uns_q ? {24'b0, ram_dout[7:0]}
                            : {{24{ram_dout[7]}}, ram_dout[7:0]};
      2'b01: ld_ext = uns_q ? {16'b0, ram_dout[15:0]}
                            : {{16{ram_dout[15]}}, ram_dout[15:0]};
      default: ld_ext = ram_dout;
    endcase
  end

  always_comb begin
    st_d     = st_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    uns_d    = uns_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    er_cnt_d = er_cnt_q;
    unique case (st_q)
      IDLE: begin
        // a request that neither loads nor stores is swallowed
        if (req_valid && (mem_rd || mem_wr)) begin
          rd_d    = mem_rd;
          wr_d    = mem_wr;
          uns_d   = unsigned_ld;
          size_d  = size;
          addr_d  = addr[RAM_AW-1:0];
          wdata_d = wdata;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            st_d    = RESP;
          end else begin
            st_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        rdata_d = rd_q ? ld_ext : 32'd0;
        st_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          st_d    = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          if (err_q)     er_cnt_d = sat_inc(er_cnt_q);
          else if (rd_q) ld_cnt_d = sat_inc(ld_cnt_q);
          else           st_cnt_d = sat_inc(st_cnt_q);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st_q     <= IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
      er_cnt_q <= '0;
    end else begin
      st_q     <= st_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      uns_q    <= uns_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
      er_cnt_q <= er_cnt_d;
    end
  end

  assign req_ready = (st_q == IDLE);
  assign rsp_valid = (st_q == RESP);
  assign ram_sel   = (st_q == ACCESS);
  // clr must kill a write in flight without waiting for the edge
  assign ram_we    = (st_q == ACCESS) && wr_q && !clr;
  assign ram_addr  = addr_q;
  assign ram_mode  = size_q;
  assign ram_din   = wdata_q;
  assign rdata     = rdata_q;
  assign addr_err  = err_q;
  assign load_cnt  = ld_cnt_q;
  assign store_cnt = st_cnt_q;
  assign err_cnt   = er_cnt_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed RAM model;
// counters are 2 bits wide so saturation shows up in the vector run.
module tb_lsu_ctrl;
  localparam int CW = 2;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          clr;
  logic          req_valid, req_ready;
  logic          mem_rd, mem_wr;
  logic [1:0]    size;
  logic          unsigned_ld;
  logic [31:0]   addr, wdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din, ram_dout;
  logic [1:0]    ram_mode;
  logic          ram_we, ram_sel;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rdata;
  logic          addr_err;
  logic [CW-1:0] load_cnt, store_cnt, err_cnt;

  lsu_ctrl #(.CNT_W(CW), .RAM_AW(AW)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_mode(ram_mode),
    .ram_we(ram_we), .ram_sel(ram_sel), .ram_dout(ram_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rdata(rdata), .addr_err(addr_err),
    .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [4096] = '{default: 8'h00};

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din[7:0];
      if (ram_mode != 2'b00) mem[ram_addr + 12'd1] <= ram_din[15:8];
      if (ram_mode == 2'b10) begin
        mem[ram_addr + 12'd2] <= ram_din[23:16];
        mem[ram_addr + 12'd3] <= ram_din[31:24];
      end
    end
  end

  always_comb begin
    ram_dout = 32'd0;
    case (ram_mode)
      2'b00: ram_dout = {24'd0, mem[ram_addr]};
      2'b01: ram_dout = {16'd0, mem[ram_addr + 12'd1], mem[ram_addr]};
      default: ram_dout = {mem[ram_addr + 12'd3], mem[ram_addr + 12'd2],
                           mem[ram_addr + 12'd1], mem[ram_addr]};
    endcase
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd);
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; mem_rd = rd; mem_wr = wr; size = sz;
    unsigned_ld = uns; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic collect(output logic [31:0] rd_o, output logic err_o,
                         output int sel_n, output int we_n, output int lat,
                         output logic [1:0] mode_s,
                         output logic [AW-1:0] addr_s);
    rd_o = 32'hxxxx_xxxx; err_o = 1'bx;
    sel_n = 0; we_n = 0; lat = 0; mode_s = 2'bxx; addr_s = 'x;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ram_sel) begin
        sel_n++; mode_s = ram_mode; addr_s = ram_addr;
      end
      if (ram_we) we_n++;
      if (rsp_valid) begin
        rd_o = rdata; err_o = addr_err; lat = k;
        break;
      end
    end
    if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  function automatic int sat(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0]   g_rd;
    logic          g_err;
    int            g_sel, g_we, g_lat;
    logic [1:0]    g_mode;
    logic [AW-1:0] g_addr;
    int            e_ld, e_st, e_er;
    logic [31:0]   h_rd;
    logic          h_err;
    int            bad;

    vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h21,   32'h80,       32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h21,   32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h21,   32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h32,   32'h8001,     32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h32,   32'h0,        32'hFFFF8001, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h32,   32'h0,        32'h00008001, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h13,   32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h01,   32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h00,   32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1};

    clr = 1'b1; req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    size = 2'b00; unsigned_ld = 1'b0; addr = 32'd0; wdata = 32'd0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_ram_sel", 32'(ram_sel), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_cnts", {26'd0, load_cnt, store_cnt, err_cnt}, 32'd0);
    clr = 1'b0;
    e_ld = 0; e_st = 0; e_er = 0;

    // neither load nor store: stays idle
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("noop_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("noop_sel_rsp", {30'd0, ram_sel, rsp_valid}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns,
            vecs[i].a, vecs[i].wd);
      collect(g_rd, g_err, g_sel, g_we, g_lat, g_mode, g_addr);
      chk($sformatf("v%0d_rdata", i), g_rd, vecs[i].erd);
      chk($sformatf("v%0d_err", i), 32'(g_err), 32'(vecs[i].eerr));
      chk($sformatf("v%0d_sel", i), 32'(g_sel), vecs[i].eerr ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_we", i), 32'(g_we),
          (vecs[i].wr && !vecs[i].eerr) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_lat", i), 32'(g_lat), vecs[i].eerr ? 32'd1 : 32'd2);
      if (!vecs[i].eerr) begin
        chk($sformatf("v%0d_mode", i), 32'(g_mode), 32'(vecs[i].sz));
        chk($sformatf("v%0d_raddr", i), 32'(g_addr), vecs[i].a & 32'hFFF);
      end
      @(posedge clk);
      #1;
      if (vecs[i].eerr)    e_er = sat(e_er);
      else if (vecs[i].rd) e_ld = sat(e_ld);
      else                 e_st = sat(e_st);
      chk($sformatf("v%0d_ldcnt", i), 32'(load_cnt), e_ld);
      chk($sformatf("v%0d_stcnt", i), 32'(store_cnt), e_st);
      chk($sformatf("v%0d_ercnt", i), 32'(err_cnt), e_er);
      chk($sformatf("v%0d_idle", i), {30'd0, rsp_valid, req_ready}, 32'd1);
    end

    // backpressure: response held for 5 cycles
    rsp_ready = 1'b0;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    collect(g_rd, g_err, g_sel, g_we, g_lat, g_mode, g_addr);
    h_rd = rdata; h_err = addr_err;
    chk("bp_rdata0", h_rd, 32'hDEADBEEF);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rdata !== h_rd || addr_err !== h_err)
        bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {30'd0, rsp_valid, req_ready}, 32'd1);
    chk("bp_rdata_clr", rdata, 32'd0);

    // clr during RESP drops the response uncounted
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    rsp_ready = 1'b0;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    collect(g_rd, g_err, g_sel, g_we, g_lat, g_mode, g_addr);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    rsp_ready = 1'b1;
    chk("resp_clr_valid", 32'(rsp_valid), 32'd0);
    chk("resp_clr_ldcnt", 32'(load_cnt), 32'd0);

    // clr during ACCESS kills the store
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678);
    chk("acc_we_before", 32'(ram_we), 32'd1);
    clr = 1'b1;
    #1;
    chk("acc_we_clr", 32'(ram_we), 32'd0);
    @(posedge clk); #1; clr = 1'b0;
    chk("acc_clr_state", {30'd0, rsp_valid, req_ready}, 32'd1);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("acc_clr_norsp", 32'(bad), 32'd0);
    chk("acc_clr_stcnt", 32'(store_cnt), 32'd0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    collect(g_rd, g_err, g_sel, g_we, g_lat, g_mode, g_addr);
    chk("acc_clr_lw", g_rd, 32'd0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
